// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises the serial line, qualifies the start bit at mid-bit,
// samples eight data bits LSB-first and strobes each good byte (or a framing error) for one cycle.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [9:0] HALF_BIT = 10'((CLKS_PER_BIT - 1) / 2);
    localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_state;
    logic [9:0] r_clk_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ferr;

    logic w_fall;
    logic w_bit_end;

    assign w_fall    = r_prev & ~r_sync2;
    assign w_bit_end = (r_clk_cnt == LAST_CNT);

    // Synchroniser and edge history reset to idle-high so release of reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_BIT) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 10'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift[r_bit_idx] <= r_sync2;
                        r_clk_cnt          <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 10'd1;
                    end
                end
                S_STOP: begin
                    // Leave at the mid-stop sample so a back-to-back start edge is not missed.
                    if (w_bit_end) begin
                        if (r_sync2) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 10'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus glitch, latency and reset sequences.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = (CPB - 1) / 2;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned period_ns;
        int unsigned gap;
        logic        exp_err;
        logic [7:0]  exp_data;   // byte for a good frame, held rx_data for a framing error
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    vec_t vecs[8];
    ev_t  exp_q[$];
    int   tests;
    int   fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned p);
        rx_serial = 1'b0;
        #(p);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            #(p);
        end
        rx_serial = stop;
        #(p);
        rx_serial = 1'b1;
    endtask

    // Every strobe must match the next expected event; an unexpected strobe is a failure.
    task automatic monitor();
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rx_valid && rx_frame_err) begin
                check("valid_and_ferr_exclusive", 32'd1, 32'd0);
            end
            if (rx_valid || rx_frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, rx_frame_err, rx_valid}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("strobe_kind_ferr", 32'(rx_frame_err), 32'(ev.is_err));
                    check(ev.is_err ? "held_rx_data" : "rx_data", 32'(rx_data), 32'(ev.data));
                end
            end
        end
    endtask

    initial begin
        int unsigned cnt;
        ev_t ev;
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        rx_serial = 1'b1;

        // Fast side uses 15.4 clocks per bit: 15 drifts bit 7 past its window under centre sampling.
        vecs[0] = '{8'hA5, 1'b1, 160, 10, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 160,  0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 160,  0, 1'b0, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, 160, 10, 1'b0, 8'h55};
        vecs[4] = '{8'h3C, 1'b0, 160, 20, 1'b1, 8'h55};
        vecs[5] = '{8'h81, 1'b1, 160, 10, 1'b0, 8'h81};
        vecs[6] = '{8'hC3, 1'b1, 170, 10, 1'b0, 8'hC3};
        vecs[7] = '{8'hC3, 1'b1, 154, 10, 1'b0, 8'hC3};

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_rx_data",  32'(rx_data),      32'd0);
        check("reset_rx_valid", 32'(rx_valid),     32'd0);
        check("reset_rx_ferr",  32'(rx_frame_err), 32'd0);
        check("reset_rx_busy",  32'(rx_busy),      32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset_busy", 32'(rx_busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            ev.is_err = vecs[v].exp_err;
            ev.data   = vecs[v].exp_data;
            exp_q.push_back(ev);
            send_byte(vecs[v].data, vecs[v].stop, vecs[v].period_ns);
            repeat (vecs[v].gap) @(negedge clk);
            if (vecs[v].gap > 0) begin
                check("busy_after_frame", 32'(rx_busy), 32'd0);
                check("events_drained", 32'(exp_q.size()), 32'd0);
            end
        end

        // Latency: strobe expected 2 + HALF + 1 + 9*CPB + 1 cycles after the start edge.
        ev.is_err = 1'b0;
        ev.data   = 8'h5A;
        exp_q.push_back(ev);
        fork
            send_byte(8'h5A, 1'b1, CPB * 10);
        join_none
        cnt = 0;
        while (!rx_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (cnt + 2 < 2 + HALF + 1 + 9 * CPB + 1 || cnt > 2 + HALF + 1 + 9 * CPB + 1 + 2) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-2", cnt, 2 + HALF + 1 + 9 * CPB + 1);
        end
        repeat (20) @(negedge clk);

        // Short low glitch must be rejected at the start-bit centre.
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_raised", 32'(rx_busy), 32'd1);
        @(negedge clk);
        rx_serial = 1'b1;
        cnt = 0;
        while (rx_busy && cnt <= HALF + 3) begin
            @(negedge clk);
            cnt++;
        end
        check("glitch_busy_cleared", 32'(rx_busy), 32'd0);
        repeat (20) @(negedge clk);

        // Reset in the middle of bit 3 of 8'hF0 aborts the frame silently.
        rx_serial = 1'b0;
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        rst       = 1'b0;
        rx_serial = 1'b1;
        #1;
        check("midreset_rx_data",  32'(rx_data),      32'd0);
        check("midreset_rx_busy",  32'(rx_busy),      32'd0);
        repeat (5) @(negedge clk);
        check("midreset_rx_valid", 32'(rx_valid),     32'd0);
        check("midreset_rx_ferr",  32'(rx_frame_err), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("after_midreset_busy", 32'(rx_busy), 32'd0);
        ev.is_err = 1'b0;
        ev.data   = 8'h12;
        exp_q.push_back(ev);
        send_byte(8'h12, 1'b1, CPB * 10);
        repeat (10) @(negedge clk);
        check("final_busy", 32'(rx_busy), 32'd0);
        check("final_rx_data", 32'(rx_data), 32'h12);
        check("final_events_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
